paddle_ctrl: RTL and testbench

//   Converts the raw right/left push-buttons into the paddle X position consumed by the pong

---
 rtl/paddle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_paddle_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// paddle_ctrl
//   Turns the raw right/left push-buttons into the paddle X position used by the
//   pong renderer. Each button is synchronised and debounced. The paddle then
//   moves once per video frame. Speed ramps up while a direction is held, and the
//   position is clamped to the visible field.
//
// Ports
//   clock_100Mhz  in   system clock, all logic on its rising edge
//   rst           in   asynchronous active-low reset
//   right, left   in   raw buttons, asynchronous to the clock, 1 = pressed
//   frame_tick    in   one-cycle pulse per frame (start of vertical blanking)
//   paddlePos     out  paddle left-edge X coordinate
//   speed         out  current step size in pixels per frame
//   at_edge       out  1 while paddlePos sits at either end of the field
module paddle_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int POS_W           = 10,
    parameter int POS_MAX         = 700,
    parameter int POS_RESET       = 350,
    parameter int MIN_STEP        = 2,
    parameter int MAX_STEP        = 8,
    parameter int ACCEL_FRAMES    = 4
) (
    input  logic             clock_100Mhz,
    input  logic             rst,
    input  logic             right,
    input  logic             left,
    input  logic             frame_tick,
    output logic [POS_W-1:0] paddlePos,
    output logic [3:0]       speed,
    output logic             at_edge
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FC_W  = $clog2(ACCEL_FRAMES) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_R = 2'd1,
        MOVE_L = 2'd2
    } state_t;

    // Index 0 is the right button, index 1 is the left button.
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       db_q;
    logic [CNT_W-1:0] dbCnt_q [2];

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [3:0]       speed_q, speed_d;
    logic [FC_W-1:0]  frameCnt_q, frameCnt_d;

    // Two-flop synchroniser, then a per-button stability counter.
    // The counter only runs while the synchronised level disagrees with the
    // accepted level. The accepted level flips once the disagreement has lasted
    // DEBOUNCE_CYCLES clocks, so any bounce shorter than that is discarded.
    always_ff @(posedge clock_100Mhz or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
            db_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            meta_q <= {left, right};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == db_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (dbCnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    dbCnt_q[i] <= '0;
                    db_q[i]    <= sync_q[i];
                end else begin
                    dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
                end
            end
        end
    end

    // State, position, speed and the acceleration counter all advance only
    // on frame_tick, so the outputs stay frozen for the whole visible frame.
    always_ff @(posedge clock_100Mhz or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pos_q      <= POS_W'(POS_RESET);
            speed_q    <= 4'(MIN_STEP);
            frameCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            speed_q    <= speed_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Next-state, move and speed-ramp logic.
    // The move always uses the speed held before this tick. A reversal, a
    // return to IDLE, or a clamp against either edge drops the paddle back to
    // its slowest speed. Entering a move from IDLE counts as the first frame
    // of continuous motion.
    always_comb begin
        logic             goR;
        logic             goL;
        logic             clamp;
        logic [POS_W:0]   sum;

        state_d    = state_q;
        pos_d      = pos_q;
        speed_d    = speed_q;
        frameCnt_d = frameCnt_q;
        goR        = db_q[0] & ~db_q[1];
        goL        = db_q[1] & ~db_q[0];
        clamp      = 1'b0;
        sum        = {1'b0, pos_q} + (POS_W+1)'(speed_q);

        if (frame_tick) begin
            if (goR) begin
                state_d = MOVE_R;
            end else if (goL) begin
                state_d = MOVE_L;
            end else begin
                state_d = IDLE;
            end

            case (state_d)
                MOVE_R: begin
                    if (sum > (POS_W+1)'(POS_MAX)) begin
                        pos_d = POS_W'(POS_MAX);
                        clamp = 1'b1;
                    end else begin
                        pos_d = sum[POS_W-1:0];
                    end
                end
                MOVE_L: begin
                    if (pos_q < POS_W'(speed_q)) begin
                        pos_d = '0;
                        clamp = 1'b1;
                    end else begin
                        pos_d = pos_q - POS_W'(speed_q);
                    end
                end
                default: begin
                end
            endcase

            if (state_d == IDLE || clamp || (state_q != IDLE && state_q != state_d)) begin
                speed_d    = 4'(MIN_STEP);
                frameCnt_d = '0;
            end else if (frameCnt_q == FC_W'(ACCEL_FRAMES - 1)) begin
                frameCnt_d = '0;
                speed_d    = (speed_q >= 4'(MAX_STEP)) ? 4'(MAX_STEP) : speed_q + 4'd1;
            end else begin
                frameCnt_d = frameCnt_q + 1'b1;
            end
        end
    end

    assign paddlePos = pos_q;
    assign speed     = speed_q;
    assign at_edge   = (pos_q == '0) || (pos_q == POS_W'(POS_MAX));

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl
//   Self-checking bench for paddle_ctrl, run with a short debounce (4 clocks)
//   and a frame_tick every 20 clocks. The buttons are changed at the start of
//   each frame and held for the whole frame. This lets the reference model work
//   purely frame by frame: it takes the pressed buttons and gives the new
//   position and speed.
module tb_paddle_ctrl;

    localparam int DEB       = 4;
    localparam int POS_MAX   = 700;
    localparam int POS_RESET = 350;
    localparam int MIN_STEP  = 2;
    localparam int MAX_STEP  = 8;
    localparam int ACCEL     = 4;

    logic       clock_100Mhz = 1'b0;
    logic       rst          = 1'b0;
    logic       right        = 1'b0;
    logic       left         = 1'b0;
    logic       frame_tick   = 1'b0;
    logic [9:0] paddlePos;
    logic [3:0] speed;
    logic       at_edge;

    int checks = 0;
    int errors = 0;

    // Reference model state: position, current direction (0 none, 1 right, 2 left)
    // and the number of frames of uninterrupted motion since the last slow-down.
    int mPos = POS_RESET;
    int mDir = 0;
    int mRun = 0;

    typedef struct {
        logic r;
        logic l;
        int   pos;
        int   spd;
        logic atEdge;
    } vec_t;

    vec_t vecs [15];

    paddle_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .POS_W          (10),
        .POS_MAX        (POS_MAX),
        .POS_RESET      (POS_RESET),
        .MIN_STEP       (MIN_STEP),
        .MAX_STEP       (MAX_STEP),
        .ACCEL_FRAMES   (ACCEL)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .rst         (rst),
        .right       (right),
        .left        (left),
        .frame_tick  (frame_tick),
        .paddlePos   (paddlePos),
        .speed       (speed),
        .at_edge     (at_edge)
    );

    // 100 MHz clock.
    always #5 clock_100Mhz = ~clock_100Mhz;

    // Speed follows from how long the paddle has been moving without interruption.
    function automatic int modelSpeed(input int run);
        int s;
        s = MIN_STEP + run / ACCEL;
        return (s > MAX_STEP) ? MAX_STEP : s;
    endfunction

    // Advance the reference model by one frame with the given buttons held.
    task automatic modelFrame(input logic r, input logic l);
        int   newDir;
        int   spd;
        logic clamp;
        newDir = (r && !l) ? 1 : ((l && !r) ? 2 : 0);
        spd    = modelSpeed(mRun);
        clamp  = 1'b0;
        if (newDir == 1) begin
            if (mPos + spd > POS_MAX) begin
                mPos  = POS_MAX;
                clamp = 1'b1;
            end else begin
                mPos = mPos + spd;
            end
        end else if (newDir == 2) begin
            if (mPos < spd) begin
                mPos  = 0;
                clamp = 1'b1;
            end else begin
                mPos = mPos - spd;
            end
        end
        if (newDir == 0 || clamp || (mDir != 0 && mDir != newDir)) begin
            mRun = 0;
        end else begin
            mRun = mRun + 1;
        end
        mDir = newDir;
    endtask

    task automatic modelReset();
        mPos = POS_RESET;
        mDir = 0;
        mRun = 0;
    endtask

    // Compare all three outputs against the expected values.
    task automatic checkOutput(input string name, input int expPos, input int expSpd,
                               input logic expEdge);
        checks++;
        if (int'(paddlePos) != expPos) begin
            errors++;
            $display("[TB] FAIL %s paddlePos got %0d expected %0d", name, paddlePos, expPos);
        end
        checks++;
        if (int'(speed) != expSpd) begin
            errors++;
            $display("[TB] FAIL %s speed got %0d expected %0d", name, speed, expSpd);
        end
        checks++;
        if (at_edge !== expEdge) begin
            errors++;
            $display("[TB] FAIL %s at_edge got %0b expected %0b", name, at_edge, expEdge);
        end
    endtask

    // One 20-clock frame: buttons are set at the start, and the tick comes on the last clock.
    // On return, the outputs already reflect this frame's tick.
    task automatic applyStimulus(input logic r, input logic l);
        @(negedge clock_100Mhz);
        right = r;
        left  = l;
        repeat (18) @(negedge clock_100Mhz);
        frame_tick = 1'b1;
        @(negedge clock_100Mhz);
        frame_tick = 1'b0;
    endtask

    task automatic modelledFrame(input string name, input logic r, input logic l);
        applyStimulus(r, l);
        modelFrame(r, l);
        checkOutput(name, mPos, modelSpeed(mRun), (mPos == 0 || mPos == POS_MAX));
    endtask

    initial begin
        // Hand-computed sequence starting from 350 in IDLE.
        // The speed ramp is 2,2,2,2,3,3,3,3,4,4.
        vecs[0]  = '{1'b1, 1'b0, 352, 2, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 354, 2, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 356, 2, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 358, 3, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 361, 3, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 364, 3, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 367, 3, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 370, 4, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 374, 4, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 378, 4, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 378, 2, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 380, 2, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 378, 2, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 376, 2, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 376, 2, 1'b0};

        // Reset state, then idle frames with no movement.
        repeat (3) @(negedge clock_100Mhz);
        checkOutput("inReset", POS_RESET, MIN_STEP, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("idleFrame", POS_RESET, MIN_STEP, 1'b0);
        end

        // Bounce: two-clock pulses never satisfy the debounce.
        for (int i = 0; i < 15; i++) begin
            right = ~right;
            repeat (2) @(negedge clock_100Mhz);
        end
        right = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("bounce", POS_RESET, MIN_STEP, 1'b0);

        // Table-driven ramp, both-pressed freeze, restart and reversal.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].r, vecs[i].l);
            checkOutput($sformatf("vec%0d", i), vecs[i].pos, vecs[i].spd, vecs[i].atEdge);
        end
        mPos = 376;
        mDir = 0;
        mRun = 0;

        // Hold left down to the left edge, then keep pushing.
        for (int i = 0; i < 80; i++) begin
            modelledFrame("leftHold", 1'b0, 1'b1);
        end
        checkOutput("leftEdge", 0, MIN_STEP, 1'b1);

        // Hold right up to the right edge.
        for (int i = 0; i < 110; i++) begin
            modelledFrame("rightHold", 1'b1, 1'b0);
        end
        checkOutput("rightEdge", POS_MAX, MIN_STEP, 1'b1);

        // Reset during a pending move: tick high and right held, reset lands between edges.
        @(negedge clock_100Mhz);
        frame_tick = 1'b1;
        #2 rst = 1'b0;
        #1 checkOutput("rstMidMoveAsync", POS_RESET, MIN_STEP, 1'b0);
        @(negedge clock_100Mhz);
        frame_tick = 1'b0;
        right      = 1'b0;
        checkOutput("rstMidMoveHeld", POS_RESET, MIN_STEP, 1'b0);
        @(negedge clock_100Mhz);
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b0, 1'b0);
        checkOutput("afterRstMove", POS_RESET, MIN_STEP, 1'b0);

        // Reset during a debounce, after the paddle has moved away from 350.
        modelledFrame("preDeb", 1'b1, 1'b0);
        @(negedge clock_100Mhz);
        right = 1'b0;
        left  = 1'b1;
        repeat (3) @(negedge clock_100Mhz);
        #2 rst = 1'b0;
        #1 checkOutput("rstMidDebAsync", POS_RESET, MIN_STEP, 1'b0);
        left = 1'b0;
        @(negedge clock_100Mhz);
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b0, 1'b0);
        checkOutput("afterRstDeb", POS_RESET, MIN_STEP, 1'b0);

        // Randomised frames checked against the reference model.
        for (int i = 0; i < 200; i++) begin
            int   v;
            logic r;
            logic l;
            v = int'($urandom_range(0, 9));
            r = (v < 4) || (v == 7);
            l = (v >= 4 && v < 8);
            modelledFrame("random", r, l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
